// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Raster timing bundle driven by vga_timing_gen and consumed by the display
// path (display_controller, level-map lookup, board connector).
//   pixelTick  : one-clk strobe, counters advance on the next edge
//   hCount     : horizontal position, 0..H_TOTAL-1
//   vCount     : vertical position, 0..V_TOTAL-1
//   hSync      : active-low horizontal sync
//   vSync      : active-low vertical sync
//   bright     : current position lies in the active area
//   frameStart : one-clk pulse on the first clk of each frame
//   tileCol    : 32-px tile column inside the active area, 0 outside it
//   tileRow    : 32-px tile row inside the active area, 0 outside it
// ---------------------------------------------------------------------------
interface vga_timing_if;
  logic       pixelTick;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frameStart;
  logic [4:0] tileCol;
  logic [3:0] tileRow;

  // Timing generator side
  modport master (
    output pixelTick, hCount, vCount, hSync, vSync, bright, frameStart,
           tileCol, tileRow
  );

  // Display / lookup side
  modport slave (
    input  pixelTick, hCount, vCount, hSync, vSync, bright, frameStart,
           tileCol, tileRow
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 raster timing from the 100 MHz system clock. A 2-bit divider
// produces the 25 MHz pixel strobe; horizontal and vertical counters step on
// that strobe. Sync, active-area and tile decodes are registered from the
// next-state counter values, so they line up with hCount/vCount on the same
// clk (no pipeline skew).
// Ports:
//   clk   : system clock (100 MHz)
//   reset : synchronous, active-high
//   vga   : vga_timing_if.master bundle (counters, syncs, bright,
//           frameStart, tile coordinates)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 783,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 514,
  parameter int unsigned TILE_SHIFT  = 5
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int unsigned DIV_W = 2;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned COL_W = 5;
  localparam int unsigned ROW_W = 4;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] H_ACT_HI   = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] V_ACT_HI   = CNT_W'(V_ACT_END);

  // Counter state
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;

  // Registered decodes
  logic             r_pixel_tick;
  logic             r_h_sync;
  logic             r_v_sync;
  logic             r_bright;
  logic [COL_W-1:0] r_tile_col;
  logic [ROW_W-1:0] r_tile_row;

  // Next-state values
  logic             w_tick;
  logic             w_h_wrap;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_pixel_tick_nxt;
  logic             w_h_sync_nxt;
  logic             w_v_sync_nxt;
  logic             w_h_act_nxt;
  logic             w_v_act_nxt;
  logic             w_bright_nxt;
  logic [CNT_W-1:0] w_h_off;
  logic [CNT_W-1:0] w_v_off;
  logic [COL_W-1:0] w_tile_col_nxt;
  logic [ROW_W-1:0] w_tile_row_nxt;
  logic             w_frame_start;

  // Divider and raster counters: next state
  always_comb begin
    w_tick    = (r_div == DIV_LAST);
    w_h_wrap  = w_tick && (r_h_count == H_LAST);
    w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
    w_h_nxt   = r_h_count;
    w_v_nxt   = r_v_count;
    if (w_tick) begin
      w_h_nxt = (r_h_count == H_LAST) ? '0 : r_h_count + CNT_W'(1);
    end
    if (w_h_wrap) begin
      w_v_nxt = (r_v_count == V_LAST) ? '0 : r_v_count + CNT_W'(1);
    end
  end

  // Decodes of the next position, so the registered copies carry no skew
  always_comb begin
    w_pixel_tick_nxt = (w_div_nxt == DIV_LAST);
    w_h_sync_nxt     = !(w_h_nxt < H_SYNC_END);
    w_v_sync_nxt     = !(w_v_nxt < V_SYNC_END);
    w_h_act_nxt      = (w_h_nxt >= H_ACT_LO) && (w_h_nxt <= H_ACT_HI);
    w_v_act_nxt      = (w_v_nxt >= V_ACT_LO) && (w_v_nxt <= V_ACT_HI);
    w_bright_nxt     = w_h_act_nxt && w_v_act_nxt;
    // 10-bit offsets wrap outside the active area; the bright gate hides that
    w_h_off          = w_h_nxt - H_ACT_LO;
    w_v_off          = w_v_nxt - V_ACT_LO;
    w_tile_col_nxt   = '0;
    w_tile_row_nxt   = '0;
    if (w_bright_nxt) begin
      w_tile_col_nxt = COL_W'(w_h_off >> TILE_SHIFT);
      w_tile_row_nxt = ROW_W'(w_v_off >> TILE_SHIFT);
    end
  end

  // State and decode registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div        <= '0;
      r_h_count    <= '0;
      r_v_count    <= '0;
      r_pixel_tick <= 1'b0;
      r_h_sync     <= 1'b0;
      r_v_sync     <= 1'b0;
      r_bright     <= 1'b0;
      r_tile_col   <= '0;
      r_tile_row   <= '0;
    end else begin
      r_div        <= w_div_nxt;
      r_h_count    <= w_h_nxt;
      r_v_count    <= w_v_nxt;
      r_pixel_tick <= w_pixel_tick_nxt;
      r_h_sync     <= w_h_sync_nxt;
      r_v_sync     <= w_v_sync_nxt;
      r_bright     <= w_bright_nxt;
      r_tile_col   <= w_tile_col_nxt;
      r_tile_row   <= w_tile_row_nxt;
    end
  end

  // Origin of the raster with the divider at its first phase. Masked while
  // reset is held so a long reset does not look like a stream of frames; the
  // pulse appears on the first clk after release.
  assign w_frame_start = (r_div == '0) && (r_h_count == '0) &&
                         (r_v_count == '0) && !reset;

  assign vga.pixelTick  = r_pixel_tick;
  assign vga.hCount     = r_h_count;
  assign vga.vCount     = r_v_count;
  assign vga.hSync      = r_h_sync;
  assign vga.vSync      = r_v_sync;
  assign vga.bright     = r_bright;
  assign vga.frameStart = w_frame_start;
  assign vga.tileCol    = r_tile_col;
  assign vga.tileRow    = r_tile_row;

endmodule
